pkt_framer: RTL and testbench
=============================

PKT_FRAMER -- requirements
Module: pkt_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, fixed byte width of s_data and fifo_din; only the value 8 is supported.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet; only the value 16 is supported.
REQ-003 SHALL have port wr_clk  input  1  sole clock; rising edge; same clock as the downstream FIFO write side.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  upstream byte valid.
REQ-006 SHALL have port s_data  input  8  upstream byte.
REQ-007 SHALL have port s_last  input  1  marks the final byte of a packet.
REQ-008 SHALL have port s_ready  output  1  byte accepted when s_valid && s_ready at the rising edge.
REQ-009 SHALL have port fifo_full  input  1  downstream FIFO full flag.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-011 SHALL have port fifo_din  output  8  FIFO write data.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port trunc_err  output  1  registered single-cycle pulse on truncation.
REQ-014 SHALL have port pkt_count  output  16  count of packets fully written to the FIFO; wraps 0xFFFF->0.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, DISCARD, HDR, PAYLOAD, plus a 16x8 payload buffer, a 5-bit length counter len, a 4-bit read index idx, and a trunc flag.
REQ-016 IDLE: s_ready=1; on accept, store byte in buf[0], len=1, trunc=0; go to HDR if s_last, else to COLLECT.
REQ-017 COLLECT: s_ready=1; on accept, store byte in buf[len] and increment len; go to HDR if s_last; else if new len==16, set trunc=1, pulse trunc_err next cycle, and go to DISCARD.
REQ-018 DISCARD: s_ready=1; drop accepted bytes (buffer and len unchanged); go to HDR on accepting a byte with s_last.
REQ-019 HDR and PAYLOAD: s_ready=0.
REQ-020 Header byte SHALL be {trunc, 2'b00, len[4:0]}; len is in the range 1..16; a byte with s_last arriving at len==16 is a normal end (trunc=0).
REQ-021 HDR: fifo_wr_en = !fifo_full (combinational), fifo_din = header; on a write go to PAYLOAD with idx=0.
REQ-022 PAYLOAD: fifo_wr_en = !fifo_full, fifo_din = buf[idx]; on each write increment idx; on the write where idx==len-1, increment pkt_count and go to IDLE.
REQ-023 fifo_wr_en SHALL never be asserted while fifo_full=1 or outside HDR/PAYLOAD; fifo_din SHALL be 0 when fifo_wr_en=0.
REQ-024 Stall: when fifo_full=1, state, idx, and fifo_din selection SHALL hold, with no skipped or duplicated bytes.
REQ-025 Latency with fifo_full=0: last byte accepted at edge t; header written at edge t+1; payload written at edges t+2..t+len+1; IDLE and ready to accept again at edge t+len+1 (s_ready high after it).
REQ-026 Throughput: one byte per cycle on each side; no bubble within a phase.
REQ-027 s_valid without s_last SHALL NOT trigger header emission; a packet is emitted only after s_last.

Reset
REQ-028 While rst=1: state=IDLE, len=0, idx=0, trunc=0, trunc_err=0, pkt_count=0, busy=0, fifo_wr_en=0, fifo_din=0.
REQ-029 Reset mid-packet SHALL abandon the partial packet and SHALL NOT issue any further writes for it; the FIFO shares rst and clears its partial contents.
REQ-030 Buffer contents SHALL need no reset.

Verification
REQ-031 Bench SHALL cover: 3-byte packet 0x11,0x22,0x33 (last on 0x33), fifo_full=0 -> FIFO receives 0x03,0x11,0x22,0x33 on consecutive cycles; pkt_count=1.
REQ-032 Bench SHALL cover: 1-byte packet 0xA5 with s_last -> writes 0x01,0xA5; busy for 2 cycles.
REQ-033 Bench SHALL cover: 20-byte packet 0x00..0x13 -> one trunc_err pulse after byte 0x0F; header 0x90 followed by bytes 0x00..0x0F; bytes 0x10..0x13 dropped.
REQ-034 Bench SHALL cover: 16-byte packet ending exactly at the 16th byte -> header 0x10; trunc_err stays 0.
REQ-035 Bench SHALL cover: fifo_full asserted for 3 cycles after the header of a 4-byte packet -> no writes while full; payload resumes in order with no loss or duplication.
REQ-036 Bench SHALL cover: rst asserted after the 2nd payload write of an 8-byte packet -> fifo_wr_en=0 immediately; pkt_count=0; the next packet frames correctly.

Source files
------------

// File: rtl/pkt_framer.sv
// Packet framer: buffers up to 16 upstream bytes, then writes a length/truncation
// header followed by the buffered payload into a downstream FIFO.
module pkt_framer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  busy,
    output logic                  trunc_err,
    output logic [15:0]           pkt_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        DISCARD = 3'd2,
        HDR     = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            len_q, len_d;
    logic [3:0]            idx_q, idx_d;
    logic                  trunc_q, trunc_d;
    logic                  trunc_err_q, trunc_err_d;
    logic                  busy_q, busy_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [DATA_WIDTH-1:0] pbuf_q [MAX_LEN];

    logic                  buf_we_s;
    logic [3:0]            buf_addr_s;
    logic                  ready_s;
    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] sel_s;
    logic [DATA_WIDTH-1:0] din_s;

    // Next-state, handshake and FIFO write-side decode
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        trunc_d     = trunc_q;
        trunc_err_d = 1'b0;
        pkt_count_d = pkt_count_q;
        buf_we_s    = 1'b0;
        buf_addr_s  = len_q[3:0];
        ready_s     = 1'b0;
        wr_en_s     = 1'b0;
        sel_s       = '0;
        case (state_q)
            IDLE: begin
                ready_s = 1'b1;
                if (s_valid) begin
                    buf_we_s   = 1'b1;
                    buf_addr_s = 4'd0;
                    len_d      = 5'd1;
                    trunc_d    = 1'b0;
                    state_d    = s_last ? HDR : COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                ready_s = 1'b1;
                if (s_valid) begin
                    buf_we_s = 1'b1;
                    len_d    = len_q + 5'd1;
                    if (s_last) begin
                        state_d = HDR;
                    end else if (len_q == 5'd15) begin
                        // buffer now full and no end in sight: drop the rest
                        trunc_d     = 1'b1;
                        trunc_err_d = 1'b1;
                        state_d     = DISCARD;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            DISCARD: begin
                ready_s = 1'b1;
                if (s_valid && s_last) begin
                    state_d = HDR;
                end else begin
                    state_d = DISCARD;
                end
            end
            HDR: begin
                wr_en_s = !fifo_full;
                sel_s   = {trunc_q, 2'b00, len_q};
                if (!fifo_full) begin
                    idx_d   = 4'd0;
                    state_d = PAYLOAD;
                end else begin
                    state_d = HDR;
                end
            end
            PAYLOAD: begin
                wr_en_s = !fifo_full;
                sel_s   = pbuf_q[idx_q];
                if (!fifo_full) begin
                    if ({1'b0, idx_q} == (len_q - 5'd1)) begin
                        idx_d       = 4'd0;
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (wr_en_s) begin
            din_s = sel_s;
        end else begin
            din_s = '0;
        end
        busy_d = (state_d != IDLE);
    end

    // Control state registers
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= 5'd0;
            idx_q       <= 4'd0;
            trunc_q     <= 1'b0;
            trunc_err_q <= 1'b0;
            busy_q      <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            trunc_q     <= trunc_d;
            trunc_err_q <= trunc_err_d;
            busy_q      <= busy_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Payload storage; contents are only read after being written for the current packet
    always_ff @(posedge wr_clk) begin
        if (buf_we_s) begin
            pbuf_q[buf_addr_s] <= s_data;
        end
    end

    assign s_ready    = ready_s;
    assign fifo_wr_en = wr_en_s;
    assign fifo_din   = din_s;
    assign busy       = busy_q;
    assign trunc_err  = trunc_err_q;
    assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pkt_framer.sv
// Bench for pkt_framer: table of packets checked through a FIFO-write scoreboard,
// plus directed sequences for idle gaps, FIFO back-pressure and mid-packet reset.
module tb_pkt_framer;

    logic        wr_clk    = 1'b0;
    logic        rst       = 1'b1;
    logic        s_valid   = 1'b0;
    logic [7:0]  s_data    = 8'h00;
    logic        s_last    = 1'b0;
    logic        fifo_full = 1'b0;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        busy;
    logic        trunc_err;
    logic [15:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_pkt = 0;

    logic [7:0] sb_q[$];
    int wr_cnt, first_wr_cyc, last_wr_cyc, busy_cnt, trunc_cnt, trunc_cyc;
    int last_acc_cyc, acc16_cyc;

    typedef struct {
        int         n;
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] hdr;
        int         trunc;
    } vec_t;
    vec_t vecs[6];

    pkt_framer #(.DATA_WIDTH(8), .MAX_LEN(16)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .trunc_err  (trunc_err),
        .pkt_count  (pkt_count)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO-side monitor: pops the scoreboard on every write, gathers per-packet stats
    always @(negedge wr_clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            if (trunc_err) begin
                trunc_cnt++;
                trunc_cyc = cyc;
            end
            if (fifo_wr_en) begin
                check("wr_while_full", fifo_full, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got 0x%02h expected no write", fifo_din);
                end else begin
                    check("fifo_din", fifo_din, sb_q.pop_front());
                end
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
            end else begin
                check("din_when_idle", fifo_din, 8'h00);
            end
        end
    end

    task automatic clear_stats();
        wr_cnt    = 0;
        busy_cnt  = 0;
        trunc_cnt = 0;
        trunc_cyc = -1;
        first_wr_cyc = -1;
        last_wr_cyc  = -1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        logic rdy;
        int   guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        do begin
            @(negedge wr_clk);
            rdy = s_ready;
            @(posedge wr_clk);
            #1;
            guard++;
        end while (!rdy && guard < 200);
        check("byte_accepted", rdy, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_packet(input int n, input logic [7:0] base, input logic [7:0] step,
                               input logic [7:0] hdr);
        int plen;
        logic [7:0] b;
        plen = (n > 16) ? 16 : n;
        sb_q.push_back(hdr);
        for (int i = 0; i < plen; i++) begin
            b = base + 8'(i) * step;
            sb_q.push_back(b);
        end
        clear_stats();
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i) * step;
            send_byte(b, (i == n - 1));
            if (i == 15) acc16_cyc = cyc;
        end
        last_acc_cyc = cyc;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || sb_q.size() != 0) && g < 300) begin
            @(posedge wr_clk);
            #2;
            g++;
        end
        check("drained", sb_q.size(), 0);
        check("busy_after_drain", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int plen;
        int g;
        vecs[0] = '{3,  8'h11, 8'h11, 8'h03, 0};
        vecs[1] = '{1,  8'hA5, 8'h00, 8'h01, 0};
        vecs[2] = '{20, 8'h00, 8'h01, 8'h90, 1};
        vecs[3] = '{16, 8'h40, 8'h01, 8'h10, 0};
        vecs[4] = '{15, 8'h80, 8'h03, 8'h0F, 0};
        vecs[5] = '{17, 8'hF0, 8'h01, 8'h90, 1};
        clear_stats();

        // Reset state
        repeat (3) @(posedge wr_clk);
        @(negedge wr_clk);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_din", fifo_din, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_trunc_err", trunc_err, 1'b0);
        check("rst_pkt_count", pkt_count, 16'd0);
        check("rst_s_ready", s_ready, 1'b1);
        @(posedge wr_clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;

        foreach (vecs[k]) begin
            plen = (vecs[k].n > 16) ? 16 : vecs[k].n;
            send_packet(vecs[k].n, vecs[k].base, vecs[k].step, vecs[k].hdr);
            wait_idle();
            exp_pkt++;
            check("pkt_count", pkt_count, exp_pkt);
            check("trunc_pulses", trunc_cnt, vecs[k].trunc);
            if (vecs[k].trunc != 0) check("trunc_timing", trunc_cyc, acc16_cyc);
            check("busy_cycles", busy_cnt, vecs[k].n + plen);
            check("write_count", wr_cnt, plen + 1);
            check("header_latency", first_wr_cyc, last_acc_cyc);
            check("last_write_cycle", last_wr_cyc, last_acc_cyc + plen);
            repeat (2) @(posedge wr_clk);
            #1;
        end

        // Idle gap mid-packet: nothing may be emitted before s_last
        clear_stats();
        sb_q.push_back(8'h03);
        sb_q.push_back(8'h61);
        sb_q.push_back(8'h62);
        sb_q.push_back(8'h63);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        repeat (5) @(posedge wr_clk);
        #1;
        check("gap_no_write", wr_cnt, 0);
        check("gap_busy", busy, 1'b1);
        check("gap_ready", s_ready, 1'b1);
        send_byte(8'h63, 1'b1);
        wait_idle();
        exp_pkt++;
        check("gap_pkt_count", pkt_count, exp_pkt);
        check("gap_write_count", wr_cnt, 4);

        // FIFO full for 3 cycles right after the header of a 4-byte packet
        send_packet(4, 8'h51, 8'h01, 8'h04);
        g = 0;
        do begin
            @(negedge wr_clk);
            g++;
        end while (!fifo_wr_en && g < 50);
        check("stall_header_seen", fifo_wr_en, 1'b1);
        @(posedge wr_clk);
        #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge wr_clk);
            check("stall_no_write", fifo_wr_en, 1'b0);
            check("stall_busy", busy, 1'b1);
        end
        @(posedge wr_clk);
        #1;
        fifo_full = 1'b0;
        wait_idle();
        exp_pkt++;
        check("stall_pkt_count", pkt_count, exp_pkt);
        check("stall_write_count", wr_cnt, 5);
        check("stall_last_write", last_wr_cyc, last_acc_cyc + 4 + 3);

        // Reset after the 2nd payload write of an 8-byte packet
        send_packet(8, 8'h71, 8'h01, 8'h08);
        g = 0;
        while (wr_cnt < 3 && g < 100) begin
            @(negedge wr_clk);
            #1;
            g++;
        end
        check("rst_test_progress", wr_cnt, 3);
        @(posedge wr_clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_wr_en", fifo_wr_en, 1'b0);
        check("midrst_din", fifo_din, 8'h00);
        check("midrst_pkt_count", pkt_count, 16'd0);
        check("midrst_busy", busy, 1'b0);
        sb_q.delete();
        exp_pkt = 0;
        repeat (2) @(posedge wr_clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge wr_clk);
        #1;
        check("abandoned_no_writes", wr_cnt, 3);
        check("post_rst_ready", s_ready, 1'b1);

        send_packet(5, 8'hC1, 8'h02, 8'h05);
        wait_idle();
        exp_pkt++;
        check("post_rst_pkt_count", pkt_count, exp_pkt);
        check("post_rst_write_count", wr_cnt, 6);
        check("post_rst_latency", first_wr_cyc, last_acc_cyc);

        check("final_sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
